// File: rtl/atm_ledger_server_pkg.sv
// Shared types for the ATM ledger server: request/status codes, FSM states, request record
// and the default account-ID table (ID 10*(i+1) at index i).
package atm_ledger_server_pkg;
  localparam int ACC_IDX_W = 4;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_DEPOSIT  = 2'd2,
    OP_TRANSFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_ERR_ID       = 3'd1,
    ST_ERR_BALANCE  = 3'd2,
    ST_ERR_DEST     = 3'd3,
    ST_ERR_OVERFLOW = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_EXECUTE = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] id;
    logic [7:0] dest_id;
    logic [7:0] amount;
  } req_t;

  // Index 0 sits in the least significant byte.
  localparam logic [79:0] DEFAULT_ID_TABLE = {
    8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10
  };
endpackage

// File: rtl/atm_ledger_server_search.sv
// Ledger search unit: scans the read-only account-ID table one index per cycle, matching source
// and destination IDs in parallel; lowest matching index wins. o_done is high on the final compare edge.
module atm_ledger_server_search
  import atm_ledger_server_pkg::*;
#(
  parameter int                          NUM_ACCOUNTS = 10,
  parameter logic [8*NUM_ACCOUNTS-1:0]   ID_TABLE     = DEFAULT_ID_TABLE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [7:0]           i_id,
  input  logic [7:0]           i_dest_id,
  output logic                 o_found,
  output logic [ACC_IDX_W-1:0] o_idx,
  output logic                 o_dest_found,
  output logic [ACC_IDX_W-1:0] o_dest_idx,
  output logic                 o_done
);
  logic [7:0]           w_rom [NUM_ACCOUNTS];
  logic                 r_busy;
  logic [ACC_IDX_W-1:0] r_cnt;
  logic                 r_found;
  logic [ACC_IDX_W-1:0] r_idx;
  logic                 r_dest_found;
  logic [ACC_IDX_W-1:0] r_dest_idx;
  logic                 w_last;

  for (genvar g = 0; g < NUM_ACCOUNTS; g++) begin : g_rom
    assign w_rom[g] = ID_TABLE[g*8 +: 8];
  end

  assign w_last = r_busy && (r_cnt == ACC_IDX_W'(NUM_ACCOUNTS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_found      <= 1'b0;
      r_idx        <= '0;
      r_dest_found <= 1'b0;
      r_dest_idx   <= '0;
    end else if (i_start) begin
      r_busy       <= 1'b1;
      r_cnt        <= '0;
      r_found      <= 1'b0;
      r_idx        <= '0;
      r_dest_found <= 1'b0;
      r_dest_idx   <= '0;
    end else if (r_busy) begin
      // Earlier hits are never overwritten, so the lowest index sticks.
      if (!r_found && (w_rom[r_cnt] == i_id)) begin
        r_found <= 1'b1;
        r_idx   <= r_cnt;
      end
      if (!r_dest_found && (w_rom[r_cnt] == i_dest_id)) begin
        r_dest_found <= 1'b1;
        r_dest_idx   <= r_cnt;
      end
      r_cnt  <= r_cnt + 1'b1;
      r_busy <= !w_last;
    end
  end

  assign o_found      = r_found;
  assign o_idx        = r_idx;
  assign o_dest_found = r_dest_found;
  assign o_dest_idx   = r_dest_idx;
  assign o_done       = w_last;
endmodule

// File: rtl/atm_ledger_server.sv
// Bank-side ledger: owns all account balances and executes BALANCE/WITHDRAW/DEPOSIT/TRANSFER.
// Response arrives N+1 edges after acceptance and is held until consumed.
module atm_ledger_server
  import atm_ledger_server_pkg::*;
#(
  parameter int                        NUM_ACCOUNTS = 10,
  parameter logic [7:0]                INIT_BALANCE = 8'd100,
  parameter logic [8*NUM_ACCOUNTS-1:0] ID_TABLE     = DEFAULT_ID_TABLE
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [1:0] i_req_op,
  input  logic [7:0] i_req_id,
  input  logic [7:0] i_req_dest_id,
  input  logic [7:0] i_req_amount,
  output logic       o_resp_valid,
  input  logic       i_resp_ready,
  output logic [2:0] o_resp_status,
  output logic [7:0] o_resp_balance
);
  state_e               r_state;
  req_t                 r_req;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [2:0]           r_resp_status;
  logic [7:0]           r_resp_balance;
  logic [7:0]           r_bal [NUM_ACCOUNTS];

  logic                 w_start;
  logic                 w_found, w_dest_found, w_done;
  logic [ACC_IDX_W-1:0] w_src_idx, w_dst_idx;
  logic [7:0]           w_src_bal, w_dst_bal, w_src_new, w_dst_new, w_resp_bal;
  logic [8:0]           w_sum_src, w_sum_dst;
  logic                 w_wr_src, w_wr_dst;
  status_e              w_status;

  assign w_start = (r_state == S_IDLE) && i_req_valid && r_req_ready;

  atm_ledger_server_search #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ID_TABLE     (ID_TABLE)
  ) u_search (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (w_start),
    .i_id         (r_req.id),
    .i_dest_id    (r_req.dest_id),
    .o_found      (w_found),
    .o_idx        (w_src_idx),
    .o_dest_found (w_dest_found),
    .o_dest_idx   (w_dst_idx),
    .o_done       (w_done)
  );

  assign w_src_bal = r_bal[w_src_idx];
  assign w_dst_bal = r_bal[w_dst_idx];
  assign w_sum_src = {1'b0, w_src_bal} + {1'b0, r_req.amount};
  assign w_sum_dst = {1'b0, w_dst_bal} + {1'b0, r_req.amount};

  // Error checks are ordered: id, dest, balance, overflow.
  always_comb begin
    w_status  = ST_OK;
    w_wr_src  = 1'b0;
    w_wr_dst  = 1'b0;
    w_src_new = w_src_bal;
    w_dst_new = w_dst_bal;
    if (!w_found) begin
      w_status = ST_ERR_ID;
    end else begin
      case (r_req.op)
        OP_WITHDRAW: begin
          if (r_req.amount > w_src_bal) w_status = ST_ERR_BALANCE;
          else begin
            w_src_new = w_src_bal - r_req.amount;
            w_wr_src  = 1'b1;
          end
        end
        OP_DEPOSIT: begin
          if (w_sum_src[8]) w_status = ST_ERR_OVERFLOW;
          else begin
            w_src_new = w_sum_src[7:0];
            w_wr_src  = 1'b1;
          end
        end
        OP_TRANSFER: begin
          if (!w_dest_found || (w_dst_idx == w_src_idx)) w_status = ST_ERR_DEST;
          else if (r_req.amount > w_src_bal)             w_status = ST_ERR_BALANCE;
          else if (w_sum_dst[8])                         w_status = ST_ERR_OVERFLOW;
          else begin
            w_src_new = w_src_bal - r_req.amount;
            w_dst_new = w_sum_dst[7:0];
            w_wr_src  = 1'b1;
            w_wr_dst  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    w_resp_bal = w_found ? w_src_new : 8'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_req          <= '0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_status  <= 3'd0;
      r_resp_balance <= 8'd0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) r_bal[i] <= INIT_BALANCE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req       <= '{op: op_e'(i_req_op), id: i_req_id,
                             dest_id: i_req_dest_id, amount: i_req_amount};
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: if (w_done) r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (w_wr_src) r_bal[w_src_idx] <= w_src_new;
          if (w_wr_dst) r_bal[w_dst_idx] <= w_dst_new;
          r_resp_status  <= w_status;
          r_resp_balance <= w_resp_bal;
          r_resp_valid   <= 1'b1;
          r_state        <= S_RESPOND;
        end
        S_RESPOND: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_status  = r_resp_status;
  assign o_resp_balance = r_resp_balance;
endmodule
